// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/load-store memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   instr_address,
  input  logic                instr_read,
  output logic [DATA_W-1:0]   instr_readdata,
  output logic                instr_waitrequest,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_byteenable,
  input  logic [DATA_W-1:0]   data_writedata,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                data_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest
);

  arb_state_t state_q, state_d;
  grant_t     grant_q, grant_d;
  grant_t     last_grant_q, last_grant_d;
  logic       wr_q, wr_d;

  logic instr_req, data_req;
  assign instr_req = instr_read;
  assign data_req  = data_read | data_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GNT_INSTR;
      last_grant_q <= GNT_DATA;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
    end
  end

  // The operation type is latched at grant so mem_read/mem_write never depend on live requests.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    case (state_q)
      IDLE: begin
        if (instr_req || data_req) begin
          if (instr_req && data_req)
            grant_d = (last_grant_q == GNT_DATA) ? GNT_INSTR : GNT_DATA;
          else
            grant_d = instr_req ? GNT_INSTR : GNT_DATA;
          wr_d         = (grant_d == GNT_DATA) && data_write;
          last_grant_d = grant_d;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (!mem_waitrequest)
          state_d = wr_q ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_byteenable    = '0;
    mem_writedata     = '0;
    instr_readdata    = '0;
    data_readdata     = '0;
    instr_waitrequest = instr_req;
    data_waitrequest  = data_req;
    case (state_q)
      BUSY: begin
        mem_read  = !wr_q;
        mem_write = wr_q;
        if (grant_q == GNT_INSTR) begin
          mem_address = instr_address;
        end else begin
          mem_address    = data_address;
          mem_byteenable = data_byteenable;
          mem_writedata  = data_writedata;
          if (wr_q && !mem_waitrequest)
            data_waitrequest = 1'b0;
        end
      end
      RESP: begin
        if (grant_q == GNT_INSTR) begin
          instr_readdata    = mem_readdata;
          instr_waitrequest = 1'b0;
        end else begin
          data_readdata    = mem_readdata;
          data_waitrequest = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
